// File: rtl/rv64g_pkg.sv
// Shared core-wide constants.
// Holds the architectural register count used by register tracking blocks.
package rv64g_pkg;

    localparam int NUM_REGS = 64;

endpackage

// File: rtl/reg_lock_tbl.sv
// Register lock table: per-register busy bits with jump fencing.
// Optional protocol checker enabled by defining REG_LOCK_ERR_CHK_EN.
module reg_lock_tbl
    import rv64g_pkg::*;
#(
    parameter int NR  = NUM_REGS,
    parameter int NWB = 2
) (
    input  logic                          clk_i,
    input  logic                          arst_ni,
    input  logic                          issue_valid_i,
    input  logic                          issue_jump_i,
    input  logic [$clog2(NR)-1:0]         issue_rd_i,
    input  logic [NWB-1:0]                wb_valid_i,
    input  logic [NWB-1:0][$clog2(NR)-1:0] wb_rd_i,
    input  logic                          jump_done_i,
    output logic [NR-1:0]                 locks_o,
    output logic                          jump_pend_o,
    output logic [$clog2(NR):0]           lock_cnt_o,
    output logic                          err_o
);

    localparam int RW = $clog2(NR);

    typedef enum logic {
        RUN  = 1'b0,
        JUMP = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [NR-1:0]   real_locks;
    logic [NR-1:0]   locks_d;
    logic [NR-1:0]   set_vec;
    logic [NR-1:0]   clr_vec;

    // Build set/clear masks; issue is applied after clears so it wins.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (state_q == RUN && issue_valid_i && issue_rd_i != '0) begin
            set_vec[issue_rd_i] = 1'b1;
        end
        for (int k = 0; k < NWB; k++) begin
            if (wb_valid_i[k]) begin
                clr_vec[wb_rd_i[k]] = 1'b1;
            end
        end
        locks_d    = (real_locks & ~clr_vec) | set_vec;
        locks_d[0] = 1'b0;
    end

    // Next-state logic: enter JUMP on a jump issue, leave on redirect.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (issue_valid_i && issue_jump_i) begin
                    state_d = JUMP;
                end
            end
            JUMP: begin
                if (jump_done_i) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // State and lock vector registers.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q    <= RUN;
            real_locks <= '0;
        end else begin
            state_q    <= state_d;
            real_locks <= locks_d;
        end
    end

    // Popcount of the real lock vector, independent of FSM state.
    always_comb begin
        lock_cnt_o = '0;
        for (int i = 0; i < NR; i++) begin
            lock_cnt_o = lock_cnt_o + (RW+1)'(real_locks[i]);
        end
    end

    assign locks_o     = (state_q == JUMP) ? '1 : real_locks;
    assign jump_pend_o = (state_q == JUMP);

`ifdef REG_LOCK_ERR_CHK_EN
    logic err_q;
    logic err_set;

    // Flag writebacks to unlocked registers and issues during a jump.
    always_comb begin
        err_set = (state_q == JUMP) && issue_valid_i;
        for (int k = 0; k < NWB; k++) begin
            if (wb_valid_i[k] && wb_rd_i[k] != '0 &&
                !real_locks[wb_rd_i[k]] && !set_vec[wb_rd_i[k]]) begin
                err_set = 1'b1;
            end
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_reg_lock_tbl.sv
// Directed bench for reg_lock_tbl (NR=64, NWB=2).
// Error expectations follow REG_LOCK_ERR_CHK_EN when defined.
module tb_reg_lock_tbl;

    localparam int NR  = 64;
    localparam int NWB = 2;
    localparam int RW  = $clog2(NR);

`ifdef REG_LOCK_ERR_CHK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic                    clk;
    logic                    arst_ni;
    logic                    issue_valid_i;
    logic                    issue_jump_i;
    logic [RW-1:0]           issue_rd_i;
    logic [NWB-1:0]          wb_valid_i;
    logic [NWB-1:0][RW-1:0]  wb_rd_i;
    logic                    jump_done_i;
    logic [NR-1:0]           locks_o;
    logic                    jump_pend_o;
    logic [RW:0]             lock_cnt_o;
    logic                    err_o;

    int tests;
    int fails;

    reg_lock_tbl #(.NR(NR), .NWB(NWB)) dut (
        .clk_i        (clk),
        .arst_ni      (arst_ni),
        .issue_valid_i(issue_valid_i),
        .issue_jump_i (issue_jump_i),
        .issue_rd_i   (issue_rd_i),
        .wb_valid_i   (wb_valid_i),
        .wb_rd_i      (wb_rd_i),
        .jump_done_i  (jump_done_i),
        .locks_o      (locks_o),
        .jump_pend_o  (jump_pend_o),
        .lock_cnt_o   (lock_cnt_o),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        issue_valid_i = 1'b0;
        issue_jump_i  = 1'b0;
        issue_rd_i    = '0;
        wb_valid_i    = '0;
        wb_rd_i       = '0;
        jump_done_i   = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int rd, input logic jmp);
        issue_valid_i = 1'b1;
        issue_jump_i  = jmp;
        issue_rd_i    = RW'(rd);
    endtask

    task automatic wb(input int port, input int rd);
        wb_valid_i[port] = 1'b1;
        wb_rd_i[port]    = RW'(rd);
    endtask

    function automatic logic [63:0] bit_of(input int i);
        logic [63:0] v;
        v = 64'd1;
        return v << i;
    endfunction

    initial begin
        tests = 0;
        fails = 0;
        idle();
        arst_ni = 1'b0;
        #3;
        check("rst_locks", locks_o, 64'd0);
        check("rst_pend", 64'(jump_pend_o), 64'd0);
        check("rst_cnt", 64'(lock_cnt_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        step();
        arst_ni = 1'b1;
        step();

        // issue rd=5, release via wb port0 three cycles later
        issue(5, 1'b0);
        step();
        idle();
        check("lock5", locks_o, bit_of(5));
        check("cnt1", 64'(lock_cnt_o), 64'd1);
        step();
        step();
        wb(0, 5);
        step();
        idle();
        check("unlock5", locks_o, 64'd0);
        check("cnt0", 64'(lock_cnt_o), 64'd0);

        // rd=0 never locks
        issue(0, 1'b0);
        step();
        idle();
        check("rd0_locks", locks_o, 64'd0);
        check("rd0_cnt", 64'(lock_cnt_o), 64'd0);
        check("rd0_err", 64'(err_o), 64'd0);

        // issue and writeback of same register: issue wins
        issue(7, 1'b0);
        step();
        issue(7, 1'b0);
        wb(1, 7);
        step();
        idle();
        check("issue_wins", locks_o, bit_of(7));
        wb(1, 7);
        step();
        idle();
        check("clr7", locks_o, 64'd0);

        // jump fencing with clears during JUMP
        issue(3, 1'b0);
        step();
        issue(1, 1'b1);
        step();
        idle();
        check("jmp_locks", locks_o, '1);
        check("jmp_pend", 64'(jump_pend_o), 64'd1);
        check("jmp_cnt", 64'(lock_cnt_o), 64'd2);
        wb(0, 3);
        step();
        idle();
        check("jmp_clr_cnt", 64'(lock_cnt_o), 64'd1);
        check("jmp_clr_locks", locks_o, '1);
        jump_done_i = 1'b1;
        step();
        idle();
        check("jdone_locks", locks_o, 64'h2);
        check("jdone_pend", 64'(jump_pend_o), 64'd0);
        wb(0, 1);
        step();
        idle();
        check("clr1", locks_o, 64'd0);

        // dual writeback of one register counts as one clear
        issue(12, 1'b0);
        step();
        issue(4, 1'b0);
        step();
        idle();
        check("cnt2", 64'(lock_cnt_o), 64'd2);
        wb(0, 12);
        wb(1, 12);
        step();
        idle();
        check("dual_locks", locks_o, bit_of(4));
        check("dual_cnt", 64'(lock_cnt_o), 64'd1);
        check("dual_err", 64'(err_o), 64'd0);
        wb(0, 4);
        step();
        idle();

        // jump_done ignored in RUN
        jump_done_i = 1'b1;
        step();
        idle();
        check("jd_in_run", 64'(jump_pend_o), 64'd0);

        // issue ignored during JUMP
        issue(2, 1'b1);
        step();
        issue(10, 1'b0);
        step();
        idle();
        check("ign_pend", 64'(jump_pend_o), 64'd1);
        jump_done_i = 1'b1;
        step();
        idle();
        check("ign_locks", locks_o, bit_of(2));
        check("ign_err", 64'(err_o), 64'(ERR_EN));

        // reset while in JUMP abandons it
        issue(6, 1'b1);
        step();
        idle();
        check("pre_rst_pend", 64'(jump_pend_o), 64'd1);
        arst_ni = 1'b0;
        #1;
        check("rst_jmp_pend", 64'(jump_pend_o), 64'd0);
        check("rst_jmp_locks", locks_o, 64'd0);
        check("rst_jmp_err", 64'(err_o), 64'd0);
        step();
        arst_ni = 1'b1;
        step();

        // writeback to an unlocked register
        wb(0, 9);
        step();
        idle();
        check("err_set", 64'(err_o), 64'(ERR_EN));
        step();
        check("err_held", 64'(err_o), 64'(ERR_EN));
        check("err_locks", locks_o, 64'd0);
        #2;
        arst_ni = 1'b0;
        #1;
        check("err_async_clr", 64'(err_o), 64'd0);
        step();
        arst_ni = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_lock_tbl.md
REG_LOCK_TBL -- requirements
Module: reg_lock_tbl

Interface
REQ-001 SHALL have parameter NR, default rv64g_pkg::NUM_REGS, meaning number of architectural registers tracked.
REQ-002 SHALL have parameter NWB, default 2, meaning number of writeback unlock ports.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk_i  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have arst_ni  input  1  asynchronous active-low reset.
REQ-005 SHALL have issue_valid_i  input  1  granted instruction issuing this cycle.
REQ-006 SHALL have issue_jump_i  input  1  issuing instruction is a jump.
REQ-007 SHALL have issue_rd_i  input  $clog2(NR)  destination register index of issuing instruction.
REQ-008 SHALL have wb_valid_i  input  NWB  per-port writeback valid.
REQ-009 SHALL have wb_rd_i  input  NWB x $clog2(NR)  per-port writeback register index.
REQ-010 SHALL have jump_done_i  input  1  jump target resolved, pipeline redirected.
REQ-011 SHALL have locks_o  output  NR  current lock vector, fed to the grant checker's locks_i.
REQ-012 SHALL have jump_pend_o  output  1  high while in JUMP state.
REQ-013 SHALL have lock_cnt_o  output  $clog2(NR)+1  popcount of the real lock vector.
REQ-014 SHALL have err_o  output  1  sticky protocol-error flag.

Function
REQ-015 SHALL hold a registered real lock vector (real_locks) and a 2-state FSM: RUN, JUMP.
REQ-016 SHALL drive locks_o = real_locks when in RUN and all-ones when in JUMP.
REQ-017 SHALL, on issue_valid_i in RUN with issue_rd_i != 0, set real_locks[issue_rd_i] at the next edge (1-cycle latency).
REQ-018 SHALL never set real_locks[0]; bit 0 SHALL read 0 in RUN.
REQ-019 SHALL, for each port k with wb_valid_i[k], clear real_locks[wb_rd_i[k]] at the next edge, in both RUN and JUMP.
REQ-020 SHALL treat equal indices on several writeback ports as a single clear.
REQ-021 SHALL, when the same cycle issues and writes back the same register, leave the bit set (issue wins).
REQ-022 SHALL transition RUN->JUMP at the edge after issue_valid_i & issue_jump_i, also applying REQ-017 for the jump's rd.
REQ-023 SHALL transition JUMP->RUN at the edge after jump_done_i; locks_o SHALL then equal real_locks including all clears done during JUMP.
REQ-024 SHALL ignore issue_valid_i while in JUMP (no lock set, no state change).
REQ-025 SHALL ignore jump_done_i while in RUN.
REQ-026 SHALL drive jump_pend_o = 1 exactly while in JUMP.
REQ-027 SHALL compute lock_cnt_o combinationally from real_locks, independent of FSM state.

Reset
REQ-028 SHALL, on arst_ni low, immediately and asynchronously clear real_locks, enter RUN, and clear err_o; locks_o, jump_pend_o, lock_cnt_o SHALL read 0.
REQ-029 SHALL abandon any pending jump if reset asserts during JUMP.

Configuration
REQ-030 SHALL support macro REG_LOCK_ERR_CHK_EN.
REQ-031 SHALL, with REG_LOCK_ERR_CHK_EN defined, set err_o (sticky until reset) on writeback of a non-zero rd whose real_locks bit is 0 and not being set the same cycle, or on issue_valid_i while in JUMP.
REQ-032 SHALL, without REG_LOCK_ERR_CHK_EN, tie err_o to 0 and contain no checking logic.

Verification (NR=64, NWB=2)
REQ-033 SHALL test issue rd=5 at cycle N -> locks_o[5]=1, lock_cnt_o=1 at N+1; wb port0 rd=5 at N+3 -> locks_o=0 at N+4.
REQ-034 SHALL test issue rd=0 -> locks_o stays 0, lock_cnt_o=0, err_o=0.
REQ-035 SHALL test real_locks[7]=1, then issue rd=7 and wb port1 rd=7 the same cycle -> locks_o[7]=1 next cycle.
REQ-036 SHALL test lock rd=3, then jump issue rd=1 -> locks_o=all-ones, jump_pend_o=1; wb rd=3 during JUMP; jump_done_i -> locks_o=64'h2, jump_pend_o=0.
REQ-037 SHALL test with REG_LOCK_ERR_CHK_EN: wb rd=9 while unlocked -> err_o=1 next cycle and held; arst_ni low -> err_o=0 asynchronously.
REQ-038 SHALL test both wb ports rd=12 with bit 12 set -> bit cleared, lock_cnt_o decrements by 1, err_o=0.
